// File: rtl/uart_pkg.sv
// Shared definitions for the board UART blocks: FSM state encoding,
// default frame geometry and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    localparam int   DEF_CLKS_PER_BIT = 16;
    localparam int   DEF_DATA_BITS    = 8;
    localparam logic LINE_IDLE        = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous input pins. Reset value is
// configurable so an idle-high line does not look like a start bit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);

    logic meta;

    // Two back-to-back flops; only the second one is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= RESET_VAL;
            level <= RESET_VAL;
        end else begin
            meta  <= pin;
            level <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a valid/ready holding register.
// Optional even parity is compiled in with `define UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 UART_CLK,
    input  logic                 UART_RST,
    input  logic                 UART_EN,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_OVERRUN,
    output logic                 RX_PARITY_ERR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 done, ferr_set, perr_set;
    logic                 par_bad, par_bad_nxt;

    uart_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk   (UART_CLK),
        .rst   (UART_RST),
        .pin   (UART_RX),
        .level (rx_s)
    );

    // FSM state, counters and shift register.
    always_ff @(posedge UART_CLK) begin
        if (UART_RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            par_bad <= par_bad_nxt;
        end
    end

    // Next-state logic; disabling the receiver parks the FSM in IDLE.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift;
        par_bad_nxt = par_bad;
        done        = 1'b0;
        ferr_set    = 1'b0;
        perr_set    = 1'b0;
        if (!UART_EN) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            bit_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt     = '0;
                    bit_nxt     = '0;
                    par_bad_nxt = 1'b0;
                    if (rx_s != LINE_IDLE) state_nxt = ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (rx_s != LINE_IDLE) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt_nxt   = '0;
                        shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt_nxt     = '0;
                        par_bad_nxt = (^shift) ^ rx_s;
                        state_nxt   = ST_STOP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt_nxt  = '0;
                        perr_set = par_bad;
                        if (rx_s == LINE_IDLE) begin
                            done      = !par_bad;
                            state_nxt = ST_IDLE;
                        end else begin
                            ferr_set  = 1'b1;
                            state_nxt = ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    cnt_nxt = '0;
                    if (rx_s == LINE_IDLE) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Holding register, handshake and registered status pulses.
    always_ff @(posedge UART_CLK) begin
        if (UART_RST) begin
            RX_DATA      <= '0;
            RX_VALID     <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_OVERRUN   <= 1'b0;
        end else begin
            RX_FRAME_ERR <= ferr_set;
            RX_OVERRUN   <= done && RX_VALID && !RX_READY;
            if (done && (!RX_VALID || RX_READY)) begin
                RX_DATA  <= shift;
                RX_VALID <= 1'b1;
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity failure pulse, aligned with where RX_VALID would have risen.
    always_ff @(posedge UART_CLK) begin
        if (UART_RST) RX_PARITY_ERR <= 1'b0;
        else          RX_PARITY_ERR <= perr_set;
    end
`else
    assign RX_PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a scoreboard queue of expected bytes is
// filled as frames are sent and drained at each valid/ready handshake.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Pin fall to RX_VALID rise, in clock cycles as counted by cyc.
    localparam int LAT = 3 + CPB / 2 + (DB + 1 + PB) * CPB;

    logic          clk = 1'b0;
    logic          rst, en, rx, ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun, parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .UART_CLK      (clk),
        .UART_RST      (rst),
        .UART_EN       (en),
        .UART_RX       (rx),
        .RX_DATA       (rx_data),
        .RX_VALID      (rx_valid),
        .RX_READY      (ready),
        .RX_FRAME_ERR  (frame_err),
        .RX_OVERRUN    (overrun),
        .RX_PARITY_ERR (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int            checks = 0, passes = 0;
    logic [DB-1:0] exp_q[$];
    int            rises = 0, hi_cycles = 0, ferr_n = 0, ovr_n = 0, perr_n = 0;
    int            last_rise = 0;
    logic          valid_d = 1'b0;

    // Monitor: event counters plus scoreboard compare at each handshake.
    always @(negedge clk) begin
        if (rx_valid && !valid_d) begin
            rises++;
            last_rise = cyc;
        end
        valid_d = rx_valid;
        if (rx_valid)   hi_cycles++;
        if (frame_err)  ferr_n++;
        if (overrun)    ovr_n++;
        if (parity_err) perr_n++;
        if (rx_valid && ready && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL handshake: unexpected byte %02h, none expected", rx_data);
            end else begin
                logic [DB-1:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e)
                    $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
                else
                    passes++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drives one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                              input logic par_flip, output int fall);
        rx = 1'b0;
        fall = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CPB) tick();
`else
        if (par_flip) rx = 1'b0;
`endif
        rx = stop;
        repeat (CPB) tick();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rx = 1'b1; ready = 1'b0;
        repeat (3) tick();
        checks++; if (rx_data !== '0) $display("FAIL reset_data: got %02h expected 00", rx_data); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid); else passes++;
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0)
            $display("FAIL reset_flags: got fe=%b ov=%b pe=%b expected 0", frame_err, overrun, parity_err);
        else passes++;
        checks++; if (dut.state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE); else passes++;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int f, r0, h0, fe0, ov0, pe0;
        bit ok;
        ready = 1'b1;
        r0 = rises; h0 = hi_cycles; fe0 = ferr_n; ov0 = ovr_n; pe0 = perr_n;
        exp_q.push_back(8'h68);
        send_frame(8'h68, 1'b1, 1'b0, f);
        wait_drain(3 * CPB, ok);
        repeat (4) tick();
        checks++; if (!ok) $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size()); else passes++;
        checks++; if (rises - r0 !== 1) $display("FAIL basic_rises: got %0d expected 1", rises - r0); else passes++;
        checks++; if (last_rise - f !== LAT) $display("FAIL basic_latency: got %0d expected %0d", last_rise - f, LAT); else passes++;
        checks++; if (hi_cycles - h0 !== 1) $display("FAIL basic_valid_width: got %0d expected 1", hi_cycles - h0); else passes++;
        checks++; if (ferr_n != fe0 || ovr_n != ov0 || perr_n != pe0)
            $display("FAIL basic_flags: got fe=%0d ov=%0d pe=%0d expected 0", ferr_n - fe0, ovr_n - ov0, perr_n - pe0);
        else passes++;
    endtask

    task automatic test_glitch();
        int r0, fe0;
        r0 = rises; fe0 = ferr_n;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
        checks++; if (rises != r0) $display("FAIL glitch_valid: got %0d rises expected 0", rises - r0); else passes++;
        checks++; if (ferr_n != fe0) $display("FAIL glitch_ferr: got %0d expected 0", ferr_n - fe0); else passes++;
        checks++; if (dut.state !== ST_IDLE) $display("FAIL glitch_state: got %0d expected %0d", dut.state, ST_IDLE); else passes++;
    endtask

    task automatic test_frame_err();
        int f, r0, fe0;
        bit ok;
        r0 = rises; fe0 = ferr_n;
        send_frame(8'h55, 1'b0, 1'b0, f);
        repeat (40) tick();
        checks++; if (dut.state !== ST_WAIT_HIGH) $display("FAIL ferr_hold_state: got %0d expected %0d", dut.state, ST_WAIT_HIGH); else passes++;
        checks++; if (ferr_n - fe0 !== 1) $display("FAIL ferr_pulse: got %0d expected 1", ferr_n - fe0); else passes++;
        checks++; if (rises != r0) $display("FAIL ferr_valid: got %0d rises expected 0", rises - r0); else passes++;
        rx = 1'b1;
        repeat (2 * CPB) tick();
        exp_q.push_back(8'h0D);
        send_frame(8'h0D, 1'b1, 1'b0, f);
        wait_drain(3 * CPB, ok);
        checks++; if (!ok) $display("FAIL ferr_recover: got %0d pending expected 0", exp_q.size()); else passes++;
        checks++; if (ferr_n - fe0 !== 1) $display("FAIL ferr_extra: got %0d expected 1", ferr_n - fe0); else passes++;
    endtask

    task automatic test_back_to_back();
        int f, r0, ov0;
        r0 = rises; ov0 = ovr_n;
        ready = 1'b0;
        exp_q.push_back(8'h68);
        send_frame(8'h68, 1'b1, 1'b0, f);
        send_frame(8'h65, 1'b1, 1'b0, f);
        repeat (CPB) tick();
        checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else passes++;
        checks++; if (rx_data !== 8'h68) $display("FAIL ovr_data: got %02h expected 68", rx_data); else passes++;
        checks++; if (ovr_n - ov0 !== 1) $display("FAIL ovr_pulse: got %0d expected 1", ovr_n - ov0); else passes++;
        checks++; if (rises - r0 !== 1) $display("FAIL ovr_rises: got %0d expected 1", rises - r0); else passes++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_release: got %b expected 0", rx_valid); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL ovr_drain: got %0d pending expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d;
        int f, r0;
        bit ok;
        d = 8'h6C;
        ready = 1'b1;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < DB / 2; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (rx_data !== '0) $display("FAIL mid_rst_data: got %02h expected 00", rx_data); else passes++;
        checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0)
            $display("FAIL mid_rst_flags: got v=%b fe=%b ov=%b pe=%b expected 0", rx_valid, frame_err, overrun, parity_err);
        else passes++;
        checks++; if (dut.state !== ST_IDLE) $display("FAIL mid_rst_state: got %0d expected %0d", dut.state, ST_IDLE); else passes++;
        rst = 1'b0;
        repeat (CPB) tick();
        r0 = rises;
        exp_q.push_back(8'h6F);
        send_frame(8'h6F, 1'b1, 1'b0, f);
        wait_drain(3 * CPB, ok);
        checks++; if (!ok) $display("FAIL mid_rst_next: got %0d pending expected 0", exp_q.size()); else passes++;
        checks++; if (rises - r0 !== 1) $display("FAIL mid_rst_rises: got %0d expected 1", rises - r0); else passes++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int f, r0, pe0;
        bit ok;
        r0 = rises; pe0 = perr_n;
        ready = 1'b1;
        send_frame(8'h0A, 1'b1, 1'b1, f);
        repeat (2 * CPB) tick();
        checks++; if (perr_n - pe0 !== 1) $display("FAIL par_pulse: got %0d expected 1", perr_n - pe0); else passes++;
        checks++; if (rises != r0) $display("FAIL par_valid: got %0d rises expected 0", rises - r0); else passes++;
        exp_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b1, 1'b0, f);
        wait_drain(3 * CPB, ok);
        checks++; if (!ok) $display("FAIL par_good: got %0d pending expected 0", exp_q.size()); else passes++;
        checks++; if (perr_n - pe0 !== 1) $display("FAIL par_extra: got %0d expected 1", perr_n - pe0); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        repeat (4) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board UART link: the inverse of the existing `uart` transmitter. It takes the asynchronous `UART_RX` pin, finds 8N1 frames (start bit low, 8 data bits LSB-first, stop bit high) and checks the stop bit. It then presents each byte on a valid/ready holding register for downstream logic, such as the camera-control command parser.

## Interface

- `CLKS_PER_BIT`, 16: `UART_CLK` cycles per bit period (the oversample ratio). Must be an even number of at least 4.
- `DATA_BITS`, 8: number of data bits per frame.

- `UART_CLK`, input, 1: receiver clock, running at `CLKS_PER_BIT` × baud.
- `UART_RST`, input, 1: synchronous reset, active-high.
- `UART_EN`, input, 1: receiver enable (the SW0 switch, already synchronous).
- `UART_RX`, input, 1: serial line, asynchronous, idles high.
- `RX_DATA`, output, `DATA_BITS`: received byte, held stable while `RX_VALID` is high.
- `RX_VALID`, output, 1: a byte is available.
- `RX_READY`, input, 1: the consumer accepts the byte. The transfer happens on a cycle where `RX_VALID` and `RX_READY` are both high.
- `RX_FRAME_ERR`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `RX_OVERRUN`, output, 1: one-cycle pulse when a completed byte is dropped because the holding register is full.
- `RX_PARITY_ERR`, output, 1: one-cycle parity failure pulse. Tied to 0 unless parity is compiled in.

## Operation

- `UART_RX` passes through a 2-flop synchronizer. All logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
  - IDLE: when `rx_s` is 0, go to START and clear the bit-period counter.
  - START: at count `CLKS_PER_BIT/2-1`, re-sample the line. If it is 0, go to DATA with the counter cleared, so later samples land mid-bit. If it is 1, the start was a glitch: go back to IDLE with no flags.
  - DATA: sample at every count of `CLKS_PER_BIT-1`. Shift right into the shift register (first bit ends up as bit 0). After `DATA_BITS` samples, go to PARITY if compiled in, otherwise STOP.
  - STOP: sample once. If it is 1, the byte is complete; go to IDLE. If it is 0, pulse `RX_FRAME_ERR`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay here until `rx_s` is 1, then go to IDLE. This stops a held-low line (break) from producing repeated frames.
- Holding register, when a byte completes:
  - If `RX_VALID` is 0, or `RX_READY` is 1 in the same cycle, load `RX_DATA` and set `RX_VALID`.
  - Otherwise keep the old `RX_DATA`, pulse `RX_OVERRUN`, and drop the new byte.
- `RX_VALID` clears on a handshake with no simultaneous completion.
- `UART_EN` = 0:
  - The FSM is forced to IDLE and the counters are cleared.
  - The holding register and `RX_VALID` are retained, and the handshake still works.
- Counter width is `$clog2(CLKS_PER_BIT)`. The bit counter is `$clog2(DATA_BITS+1)` wide. Neither counter may wrap silently.

## Timing

- Reset values: `RX_DATA` = 0, `RX_VALID` = 0, `RX_FRAME_ERR` = 0, `RX_OVERRUN` = 0, `RX_PARITY_ERR` = 0, FSM in IDLE, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame. The first cycle after reset is in IDLE.
- Pin-to-IDLE-exit latency is 2 cycles (synchronizer), plus 1 cycle.
- `RX_VALID` rises exactly 1 cycle after the stop-bit sample cycle. With 16× oversampling, that is about 9.5 bit periods after the falling edge of the start bit.
- Error and overrun pulses are registered. They occur in the same cycle `RX_VALID` would have risen.
- Back-to-back frames are supported. The receiver is in IDLE half a bit before the stop bit ends.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
- Defined: an even-parity bit is expected between the data and stop bits. It is sampled in the PARITY state. On mismatch:
  - pulse `RX_PARITY_ERR`;
  - discard the byte;
  - still check the stop bit, and go to WAIT_HIGH if it is low.
- Undefined: there is no PARITY state, the frame is 8N1, and `RX_PARITY_ERR` is the constant 0.

## Structure

- Package `uart_pkg` holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the default `CLKS_PER_BIT` and `DATA_BITS`;
  - the idle line level.
- Sub-module `uart_sync2`: the 2-flop synchronizer, with reset value 1. It is reused for other asynchronous pins.

## Test plan

- Send 0x68 at 16×, holding `RX_READY` = 1. Expect `RX_DATA` = 0x68 with a single-cycle `RX_VALID`, 1 cycle after the stop sample, and no error flags.
- Drive `UART_RX` low for 4 cycles, then high. Expect no `RX_VALID`, no error pulses, and the FSM back in IDLE.
- Send 0x55 with the stop bit at 0, then hold the line low for 40 cycles, then release. Expect one `RX_FRAME_ERR` pulse, `RX_VALID` staying 0, and 0x0D received correctly afterwards.
- Send 0x68 then 0x65 back-to-back with `RX_READY` = 0. Expect `RX_DATA` to stay 0x68, `RX_VALID` to stay 1, and one `RX_OVERRUN` pulse. Then assert `RX_READY` for 1 cycle: `RX_VALID` drops.
- Assert `UART_RST` halfway through the data bits of 0x6C. Expect all outputs at reset values the next cycle, and the following 0x6F received correctly.
- With `UART_RX_PARITY_EN`: send 0x0A with a wrong parity bit. Expect an `RX_PARITY_ERR` pulse and no `RX_VALID`. Send 0x0A with correct parity: `RX_DATA` = 0x0A.
